// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge-latched sources, mask and global enable,
// one interrupt at a time sequenced through the pipeline backup/recovery handshake.
module irq_controller #(
  parameter int unsigned NSRC = 4,
  parameter logic [31:0] BASE = 32'h4000_0030
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic            we,
  input  logic            re,
  output logic [31:0]     rdata,
  input  logic            irq_ack,
  input  logic            irq_done,
  output logic            irqout,
  output logic [2:0]      cause
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [NSRC-1:0] src_q, pending, mask, eligible, rise, w1c, ack_clr;
  logic            gie, busy, busy_n, irqout_n;
  logic [CW-1:0]   cause_n, winner;
  logic            sel;
  logic [1:0]      word;
  logic            unused_bits;

  assign sel         = (addr[31:4] == BASE[31:4]);
  assign word        = addr[3:2];
  assign rise        = src & ~src_q;
  assign eligible    = pending & mask & {NSRC{gie}};
  assign w1c         = (we && sel && word == 2'd0) ? wdata[NSRC-1:0] : '0;
  assign unused_bits = ^{addr[1:0], wdata[31:NSRC]};

  // Lowest eligible index wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (eligible[i]) winner = CW'(i);
    end
  end

  always_comb begin
    state_n  = state;
    irqout_n = irqout;
    busy_n   = busy;
    cause_n  = cause;
    ack_clr  = '0;
    case (state)
      IDLE: begin
        irqout_n = 1'b0;
        busy_n   = 1'b0;
        if (|eligible) begin
          state_n  = REQ;
          irqout_n = 1'b1;
        end
      end
      REQ: begin
        irqout_n = 1'b1;
        if (eligible == '0) begin
          state_n  = IDLE;
          irqout_n = 1'b0;
        end else if (irq_ack) begin
          state_n  = SERVICE;
          cause_n  = winner;
          busy_n   = 1'b1;
          irqout_n = 1'b0;
          ack_clr  = NSRC'(1) << winner;
        end
      end
      SERVICE: begin
        irqout_n = 1'b0;
        busy_n   = 1'b1;
        if (irq_done) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n  = IDLE;
        irqout_n = 1'b0;
        busy_n   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state  <= IDLE;
      irqout <= 1'b0;
      busy   <= 1'b0;
      cause  <= '0;
    end else begin
      state  <= state_n;
      irqout <= irqout_n;
      busy   <= busy_n;
      cause  <= cause_n;
    end
  end

  // A fresh rise overrides both software clear and acknowledge clear.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
      gie     <= 1'b0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~w1c & ~ack_clr) | rise;
      if (we && sel && word == 2'd1) mask <= wdata[NSRC-1:0];
      if (we && sel && word == 2'd3) gie <= wdata[0];
    end
  end

  always_comb begin
    rdata = '0;
    if (re && sel) begin
      case (word)
        2'd0:    rdata = 32'(pending);
        2'd1:    rdata = 32'(mask);
        2'd2:    rdata = {28'd0, busy, cause};
        default: rdata = {31'd0, gie};
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic compared
// against a behavioural model of pending/mask/enable and the request handshake.
module tb_irq_controller;

  localparam int unsigned NSRC = 4;
  localparam logic [31:0] BASE = 32'h4000_0030;

  logic            clk, reset_b;
  logic [NSRC-1:0] src;
  logic [31:0]     addr, wdata, rdata;
  logic            we, re, irq_ack, irq_done, irqout;
  logic [2:0]      cause;

  int errors = 0;
  int checks = 0;

  logic [NSRC-1:0] m_pend, m_mask, m_srcq;
  logic            m_gie, m_irq, m_busy;
  logic [2:0]      m_cause;

  irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
    .clk(clk), .reset_b(reset_b), .src(src), .addr(addr), .wdata(wdata),
    .we(we), .re(re), .rdata(rdata), .irq_ack(irq_ack), .irq_done(irq_done),
    .irqout(irqout), .cause(cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = '0; m_mask = '0; m_srcq = '0;
    m_gie = 1'b0; m_irq = 1'b0; m_busy = 1'b0; m_cause = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return {28'd0, m_busy, m_cause};
      default: return {31'd0, m_gie};
    endcase
  endfunction

  // One clock edge of the reference behaviour, using inputs held across the edge.
  task automatic m_edge();
    logic [NSRC-1:0] elig, lowbit, clr, w1c;
    logic            hit;
    int              win;
    elig   = m_gie ? (m_pend & m_mask) : '0;
    lowbit = elig & (~elig + 1'b1);
    win    = $clog2(lowbit);
    clr    = '0;
    hit    = (addr[31:4] == BASE[31:4]);
    if (m_busy) begin
      if (irq_done) m_busy = 1'b0;
    end else if (m_irq) begin
      if (elig == '0) m_irq = 1'b0;
      else if (irq_ack) begin
        m_cause = 3'(win);
        m_busy  = 1'b1;
        m_irq   = 1'b0;
        clr     = lowbit;
      end
    end else if (elig != '0) begin
      m_irq = 1'b1;
    end
    w1c    = (we && hit && addr[3:2] == 2'd0) ? wdata[NSRC-1:0] : '0;
    m_pend = (m_pend & ~w1c & ~clr) | (src & ~m_srcq);
    if (we && hit && addr[3:2] == 2'd1) m_mask = wdata[NSRC-1:0];
    if (we && hit && addr[3:2] == 2'd3) m_gie = wdata[0];
    m_srcq = src;
  endtask

  task automatic cyc();
    #1;
    if (re) check("rdata", rdata, m_read(addr));
    @(posedge clk);
    if (!reset_b) m_edge();
    #1;
    check("irqout", 32'(irqout), 32'(m_irq));
    check("cause", 32'(cause), 32'(m_cause));
  endtask

  task automatic wr(input int w, input logic [31:0] d);
    addr = BASE + 32'(w * 4); wdata = d; we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input int w, input logic [31:0] exp);
    addr = BASE + 32'(w * 4); re = 1'b1;
    #1;
    check(tag, rdata, exp);
    re = 1'b0;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
  endtask

  task automatic pulse_done();
    irq_done = 1'b1; cyc(); irq_done = 1'b0;
  endtask

  initial begin
    reset_b = 1'b1; src = '0; addr = '0; wdata = '0;
    we = 1'b0; re = 1'b0; irq_ack = 1'b0; irq_done = 1'b0;
    m_reset();
    #2;
    check("rst_irqout", 32'(irqout), 32'd0);
    check("rst_cause", 32'(cause), 32'd0);
    @(posedge clk); #1;
    reset_b = 1'b0;

    // Single source, two-cycle latency, acknowledge.
    wr(1, 32'h2); wr(3, 32'h1);
    src = 4'b0010; cyc();
    check("t1_irq_early", 32'(irqout), 32'd0);
    src = '0; cyc();
    check("t1_irq", 32'(irqout), 32'd1);
    pulse_ack();
    check("t1_cause", 32'(cause), 32'd1);
    rd_check("t1_cause_reg", 2, 32'h9);
    rd_check("t1_pend", 0, 32'h0);
    pulse_done();

    // Priority between simultaneous sources, then the deferred one.
    wr(1, 32'hF);
    src = 4'b1001; cyc();
    src = '0; cyc();
    pulse_ack();
    check("t2_cause0", 32'(cause), 32'd0);
    rd_check("t2_pend", 0, 32'h8);
    pulse_done();
    cyc();
    check("t2_rereq", 32'(irqout), 32'd1);
    pulse_ack();
    check("t2_cause3", 32'(cause), 32'd3);
    pulse_done();

    // Withdrawn request when masked, reasserted on unmask.
    src = 4'b0001; cyc();
    src = '0; cyc();
    wr(1, 32'h0);
    cyc();
    check("t3_drop", 32'(irqout), 32'd0);
    rd_check("t3_pend", 0, 32'h1);
    wr(1, 32'hF);
    cyc();
    check("t3_reassert", 32'(irqout), 32'd1);
    pulse_ack(); pulse_done();

    // Set beats write-1-to-clear on the same edge.
    wr(1, 32'h0);
    src = 4'b0010; cyc();
    src = '0; cyc();
    src = 4'b0010; wr(0, 32'h2);
    rd_check("t4_set_wins", 0, 32'h2);
    wr(0, 32'h2);
    rd_check("t4_cleared", 0, 32'h0);
    src = '0; cyc();

    // Spurious handshake pulses and a held-high source.
    pulse_done();
    check("t5_idle_done", 32'(irqout), 32'd0);
    wr(1, 32'h1);
    src = 4'b0001; cyc(); cyc(); cyc();
    pulse_ack();
    cyc(); cyc();
    rd_check("t5_single_set", 0, 32'h0);
    pulse_ack();
    check("t5_cause_hold", 32'(cause), 32'd0);
    rd_check("t5_busy", 2, 32'h8);
    pulse_done();
    rd_check("t5_not_busy", 2, 32'h0);
    src = '0; cyc();

    // Asynchronous reset while in service with pending bits.
    wr(1, 32'hF);
    src = 4'b0100; cyc();
    src = '0; cyc();
    pulse_ack();
    check("t6_cause", 32'(cause), 32'd2);
    src = 4'b0011; cyc();
    src = '0; cyc();
    #2; reset_b = 1'b1; #1;
    check("t6_irqout", 32'(irqout), 32'd0);
    check("t6_cause_rst", 32'(cause), 32'd0);
    rd_check("t6_pend", 0, 32'h0);
    rd_check("t6_mask", 1, 32'h0);
    rd_check("t6_ctrl", 3, 32'h0);
    reset_b = 1'b0; m_reset();
    src = 4'b0001; cyc();
    src = '0; repeat (4) cyc();
    check("t6_no_req", 32'(irqout), 32'd0);

    // Randomized traffic against the model.
    wr(1, $urandom); wr(3, 32'h1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) src = NSRC'($urandom);
      we       = ($urandom_range(0, 7) == 0);
      re       = $urandom_range(0, 1) == 1;
      wdata    = $urandom;
      addr     = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) addr = BASE + 32'h10 + 32'($urandom_range(0, 15));
      if (we && addr[3:2] == 2'd3 && $urandom_range(0, 1) == 1) wdata[0] = 1'b1;
      irq_ack  = ($urandom_range(0, 2) == 0);
      irq_done = ($urandom_range(0, 3) == 0);
      cyc();
    end
    we = 1'b0; re = 1'b0; irq_ack = 1'b0; irq_done = 1'b0; src = '0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Prioritised interrupt controller between the peripheral interrupt sources (timer, UART RX, UART TX, switches) and the pipelined CPU. It edge-detects and latches source requests, applies a software mask and global enable, and raises a single `irqout` to the ID stage. It then sequences one interrupt at a time through the pipeline's backup/recovery handshake. Its registers are mapped on the MEM-stage peripheral bus.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..8.
- `BASE`, 32'h4000_0030: byte base address of the 4-word register window.

- `clk` input 1: CPU clock, rising-edge.
- `reset_b` input 1: asynchronous, active-high reset (asserted = 1).
- `src` input NSRC: raw request levels; a 0->1 transition is a request.
- `addr` input 32: MEM-stage byte address.
- `wdata` input 32: MEM-stage write data.
- `we` input 1: MEM-stage write strobe.
- `re` input 1: MEM-stage read strobe.
- `rdata` output 32: read data, combinational; 0 when not selected or `re`=0.
- `irq_ack` input 1: one-cycle pulse from ID, the IRQ_BACKUP event; the pipeline has taken the interrupt.
- `irq_done` input 1: one-cycle pulse, the IRQ_RECOVERY event; the handler has returned.
- `irqout` output 1: interrupt request to ID, registered.
- `cause` output 3: index of the source in service, registered.

## Operation
- Register selection: selected when `addr[31:4] == BASE[31:4]`; `addr[3:2]` picks the word. `addr[1:0]` is ignored.
  - 0 PEND: read pending[NSRC-1:0]; write-1-to-clear.
  - 1 MASK: read/write; bit=1 enables the source.
  - 2 CAUSE: read-only, {28'b0, busy, cause}.
  - 3 CTRL: bit0 = global enable GIE, read/write.
  - Unused bits read 0.
- Edge detect: `src_q <= src` every cycle. A rise (`src & ~src_q`) sets the pending bit at the same clock edge.
- Eligible = pending & MASK, gated by GIE.
- Priority: the lowest index among eligible sources wins.
- FSM, 3 states:
  - IDLE: `irqout` = 0. If eligible != 0, go to REQ and register `irqout` = 1.
  - REQ: `irqout` = 1.
    - On `irq_ack`: latch `cause` = winner at that cycle, clear that pending bit, set busy, drop `irqout`, go to SERVICE.
    - If eligible becomes 0 before ack (masked, cleared, or GIE off): drop `irqout` and go to IDLE. No ack is expected.
  - SERVICE: `irqout` = 0, busy = 1.
    - On `irq_done`: busy = 0, go to IDLE. `cause` holds its last value.
    - No nesting: new edges only accumulate in pending.
- Ignored events: `irq_ack` in IDLE or SERVICE; `irq_done` in IDLE or REQ.
- Reset values: `irqout` 0, `cause` 0, busy 0, state IDLE, pending 0, MASK 0, GIE 0, `src_q` 0.

## Timing
- Source rise sampled at edge N -> pending bit visible from N (read after N).
- `irqout` high at edge N+1 if MASK and GIE allow it.
- Latency from rise to `irqout` is 2 cycles when the controller is idle.
- `irq_ack` at edge M -> from M: `irqout` 0, `cause` valid, busy 1.
- `irq_done` at edge K -> earliest new `irqout` at K+1.
- Writes take effect at the clock edge where `we` is sampled. Read data reflects state before that edge.
- Simultaneous events:
  - Source rise on the same edge as a W1C of that bit: set wins.
  - Rise of the winning source on the same edge as ack: the bit stays pending (re-request).
  - `irq_ack` and a MASK write on the same edge: cause uses eligible before the write.
  - `irq_ack` and `irq_done` on the same edge in REQ: only ack is taken.
- Asynchronous reset mid-SERVICE: immediate return to reset values. `irqout` is low while reset is asserted.

## Test plan
1. Reset then MASK=4'b0010, GIE=1, pulse `src[1]` -> `irqout` 1 two cycles after the rise. Ack -> `cause`=1, CAUSE reads 32'h9, PEND reads 0.
2. `src[3]` and `src[0]` rise together, MASK=4'hF, GIE=1 -> ack gives `cause`=0. PEND=4'b1000. After `irq_done`, a second request follows and ack gives `cause`=3.
3. In REQ, write MASK=0 before ack -> `irqout` falls the next cycle, FSM in IDLE, PEND bit retained. Rewrite MASK -> `irqout` reasserts.
4. W1C PEND=4'h2 on the same cycle as a fresh `src[1]` rise -> PEND bit1 stays 1.
5. Spurious `irq_done` in IDLE and `irq_ack` in SERVICE -> no state or output change. `src` held high gives only one pending set.
6. Assert `reset_b` during SERVICE with pending bits set -> `irqout`, `cause`, PEND, MASK, CTRL all read 0 immediately. No request after release until reconfigured.
